// File: rtl/mem320_access_arbiter.sv
`default_nettype none
// ============================================================================
// mem320_access_arbiter
//   Shares the 320x320 pixel memory read port between display and processor,
//   gated by the Done640-triggered load sequence.
//   Revision: 1.0 - initial release
// ============================================================================
module mem320_access_arbiter #(
  parameter int MEM_DEPTH   = 102400,
  parameter int LOAD_CYCLES = 4,
  parameter int DISP_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Done640,
  output logic        ready,
  input  logic        disp_req,
  input  logic [17:0] disp_addr,
  output logic        disp_gnt,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  output logic        disp_err,
  input  logic        proc_req,
  input  logic [17:0] proc_addr,
  output logic        proc_gnt,
  output logic        proc_valid,
  output logic [7:0]  proc_data,
  output logic        proc_err,
  output logic [17:0] mem_address,
  input  logic [7:0]  mem_result
);

  typedef enum logic [1:0] {
    ST_UNLOADED = 2'd0,
    ST_LOADING  = 2'd1,
    ST_SERVING  = 2'd2
  } state_t;

  localparam logic [18:0] c_depth      = 19'(MEM_DEPTH);
  localparam logic [7:0]  c_load_last  = 8'(LOAD_CYCLES - 1);
  localparam logic [3:0]  c_streak_max = 4'(DISP_STREAK);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_load_cnt, w_load_cnt_nxt;
  logic        w_ready_nxt;
  logic        r_done_q;
  logic        w_rise;
  logic [3:0]  r_streak;
  logic        r_pend, r_pend_disp, r_pend_oor;
  logic        w_serve;
  logic        w_disp_elig, w_proc_elig;
  logic        w_disp_win, w_proc_win;
  logic [17:0] w_win_addr;
  logic        w_win_oor;

  assign w_rise = Done640 & ~r_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_UNLOADED;
      r_load_cnt <= '0;
      ready      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_load_cnt <= w_load_cnt_nxt;
      ready      <= w_ready_nxt;
    end
  end

  // A Done640 rising edge restarts the load from any state.
  always_comb begin
    w_state_nxt    = r_state;
    w_load_cnt_nxt = r_load_cnt;
    w_ready_nxt    = ready;
    case (r_state)
      ST_UNLOADED: begin
        if (w_rise) begin
          w_state_nxt    = ST_LOADING;
          w_load_cnt_nxt = '0;
        end
      end
      ST_LOADING: begin
        if (w_rise) begin
          w_load_cnt_nxt = '0;
        end else if (r_load_cnt == c_load_last) begin
          w_state_nxt = ST_SERVING;
          w_ready_nxt = 1'b1;
        end else begin
          w_load_cnt_nxt = r_load_cnt + 8'd1;
        end
      end
      ST_SERVING: begin
        if (w_rise) begin
          w_state_nxt    = ST_LOADING;
          w_load_cnt_nxt = '0;
          w_ready_nxt    = 1'b0;
        end
      end
      default: begin
        w_state_nxt    = ST_UNLOADED;
        w_load_cnt_nxt = '0;
        w_ready_nxt    = 1'b0;
      end
    endcase
  end

  // A requester whose grant is currently showing is ignored for this edge.
  assign w_serve     = (r_state == ST_SERVING) & ~w_rise;
  assign w_disp_elig = w_serve & disp_req & ~disp_gnt;
  assign w_proc_elig = w_serve & proc_req & ~proc_gnt;
  assign w_proc_win  = w_proc_elig & (~w_disp_elig | (r_streak == c_streak_max));
  assign w_disp_win  = w_disp_elig & ~w_proc_win;
  assign w_win_addr  = w_proc_win ? proc_addr : disp_addr;
  assign w_win_oor   = ({1'b0, w_win_addr} >= c_depth);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q    <= 1'b0;
      r_streak    <= '0;
      r_pend      <= 1'b0;
      r_pend_disp <= 1'b0;
      r_pend_oor  <= 1'b0;
      disp_gnt    <= 1'b0;
      proc_gnt    <= 1'b0;
      disp_valid  <= 1'b0;
      proc_valid  <= 1'b0;
      disp_err    <= 1'b0;
      proc_err    <= 1'b0;
      disp_data   <= '0;
      proc_data   <= '0;
      mem_address <= '0;
    end else begin
      r_done_q <= Done640;
      disp_gnt <= w_disp_win;
      proc_gnt <= w_proc_win;

      // Response for the access granted on the previous edge.
      disp_valid <= r_pend & r_pend_disp;
      proc_valid <= r_pend & ~r_pend_disp;
      disp_err   <= r_pend & r_pend_disp & r_pend_oor;
      proc_err   <= r_pend & ~r_pend_disp & r_pend_oor;
      if (r_pend & r_pend_disp) begin
        disp_data <= r_pend_oor ? 8'h00 : mem_result;
      end
      if (r_pend & ~r_pend_disp) begin
        proc_data <= r_pend_oor ? 8'h00 : mem_result;
      end

      r_pend      <= w_disp_win | w_proc_win;
      r_pend_disp <= w_disp_win;
      r_pend_oor  <= w_win_oor;
      if ((w_disp_win | w_proc_win) & ~w_win_oor) begin
        mem_address <= w_win_addr;
      end

      if (!proc_req || w_proc_win) begin
        r_streak <= '0;
      end else if (w_disp_win && w_proc_elig && (r_streak != c_streak_max)) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire
